// File: rtl/slc3_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// slc3_input_conditioner_if
// Pin bundle between the raw board inputs and the slc3 core inputs.
//   run_btn_i, continue_btn_i, reset_btn_i : raw buttons, active-high, async
//   sw_raw_i                               : raw slide switches, async
//   run_o, continue_o                      : single-cycle press pulses
//   reset_o                                : synchronous active-high core reset
//   sw_o                                   : debounced switch word
// master: the board / stimulus side.  slave: the conditioner.
// ---------------------------------------------------------------------------
interface slc3_input_conditioner_if #(
    parameter int SW_WIDTH = 16
);
    logic                run_btn_i;
    logic                continue_btn_i;
    logic                reset_btn_i;
    logic [SW_WIDTH-1:0] sw_raw_i;
    logic                run_o;
    logic                continue_o;
    logic                reset_o;
    logic [SW_WIDTH-1:0] sw_o;

    modport master (
        output run_btn_i, continue_btn_i, reset_btn_i, sw_raw_i,
        input  run_o, continue_o, reset_o, sw_o
    );

    modport slave (
        input  run_btn_i, continue_btn_i, reset_btn_i, sw_raw_i,
        output run_o, continue_o, reset_o, sw_o
    );
endinterface

// File: rtl/slc3_input_conditioner.sv
// ---------------------------------------------------------------------------
// slc3_input_conditioner
// Synchronizes and debounces the board buttons and switches for the slc3 core.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   pins  : slc3_input_conditioner_if.slave (raw pins in, conditioned out)
// Buttons are indexed 0 = run, 1 = continue, 2 = board reset button.
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module slc3_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_WIDTH        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    slc3_input_conditioner_if.slave   pins
);
    localparam int              CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    // The board reset button idles as "pressed" so the core comes up in reset
    // and stays there until the released level has been debounced.
    localparam logic [2:0]      BTN_RST_VAL = 3'b100;

    logic [2:0]          btn_raw_s;
    logic [2:0]          btn_sync1_r;
    logic [2:0]          btn_sync2_r;
    logic [2:0]          btn_d_r;
    logic [2:0]          btn_d_next_s;
    logic [2:0]          btn_rise_s;
    logic [CNT_W-1:0]    btn_cnt_r      [3];
    logic [CNT_W-1:0]    btn_cnt_next_s [3];

    logic [SW_WIDTH-1:0] sw_sync1_r;
    logic [SW_WIDTH-1:0] sw_sync2_r;
    logic [SW_WIDTH-1:0] sw_cand_r;
    logic [SW_WIDTH-1:0] sw_cand_next_s;
    logic [SW_WIDTH-1:0] sw_r;
    logic [SW_WIDTH-1:0] sw_next_s;
    logic [CNT_W-1:0]    sw_cnt_r;
    logic [CNT_W-1:0]    sw_cnt_next_s;

    logic                run_r;
    logic                cont_r;
    logic                rst_out_r;

    assign btn_raw_s = {pins.reset_btn_i, pins.continue_btn_i, pins.run_btn_i};

    // Two-flop synchronizers for every asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync1_r <= BTN_RST_VAL;
            btn_sync2_r <= BTN_RST_VAL;
            sw_sync1_r  <= {SW_WIDTH{1'b0}};
            sw_sync2_r  <= {SW_WIDTH{1'b0}};
        end else begin
            btn_sync1_r <= btn_raw_s;
            btn_sync2_r <= btn_sync1_r;
            sw_sync1_r  <= pins.sw_raw_i;
            sw_sync2_r  <= sw_sync1_r;
        end
    end

    // Button debounce next-state: any matching cycle restarts the count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_d_next_s[i]   = btn_d_r[i];
            btn_cnt_next_s[i] = CNT_ZERO;
            if (btn_sync2_r[i] != btn_d_r[i]) begin
                if (btn_cnt_r[i] == CNT_MAX) begin
                    btn_d_next_s[i]   = btn_sync2_r[i];
                    btn_cnt_next_s[i] = CNT_ZERO;
                end else begin
                    btn_cnt_next_s[i] = btn_cnt_r[i] + CNT_ONE;
                end
            end else begin
                btn_cnt_next_s[i] = CNT_ZERO;
            end
        end
        // Pulse is raised on the same edge the debounced level rises.
        btn_rise_s = btn_d_next_s & ~btn_d_r;
    end

    // Button debounce state and registered pulse / reset outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_d_r   <= BTN_RST_VAL;
            for (int i = 0; i < 3; i++) begin
                btn_cnt_r[i] <= CNT_ZERO;
            end
            run_r     <= 1'b0;
            cont_r    <= 1'b0;
            rst_out_r <= 1'b1;
        end else begin
            btn_d_r   <= btn_d_next_s;
            for (int i = 0; i < 3; i++) begin
                btn_cnt_r[i] <= btn_cnt_next_s[i];
            end
            run_r     <= btn_rise_s[0];
            cont_r    <= btn_rise_s[1];
            rst_out_r <= btn_d_next_s[2];
        end
    end

    // Switch group debounce next-state: any bit change restarts the count,
    // and the whole word is committed at once.
    always_comb begin
        sw_cand_next_s = sw_cand_r;
        sw_next_s      = sw_r;
        sw_cnt_next_s  = CNT_ZERO;
        if (sw_sync2_r != sw_cand_r) begin
            sw_cand_next_s = sw_sync2_r;
        end else if (sw_cand_r != sw_r) begin
            if (sw_cnt_r == CNT_MAX) begin
                sw_next_s = sw_cand_r;
            end else begin
                sw_cnt_next_s = sw_cnt_r + CNT_ONE;
            end
        end else begin
            sw_cnt_next_s = CNT_ZERO;
        end
    end

    // Switch group debounce state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_cand_r <= {SW_WIDTH{1'b0}};
            sw_r      <= {SW_WIDTH{1'b0}};
            sw_cnt_r  <= CNT_ZERO;
        end else begin
            sw_cand_r <= sw_cand_next_s;
            sw_r      <= sw_next_s;
            sw_cnt_r  <= sw_cnt_next_s;
        end
    end

    assign pins.run_o      = run_r;
    assign pins.continue_o = cont_r;
    assign pins.reset_o    = rst_out_r;
    assign pins.sw_o       = sw_r;
endmodule

// File: tb/tb_slc3_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_slc3_input_conditioner
// Directed bench for slc3_input_conditioner with DEBOUNCE_CYCLES = 4.
// Each table row drives the inputs, advances one clock and compares all
// outputs; hand-written sequences cover bounce, switch restart and
// mid-count reset.
// ---------------------------------------------------------------------------
module tb_slc3_input_conditioner;
    localparam int D = 4;
    localparam int W = 16;

    typedef struct {
        logic         rst_n;
        logic         run;
        logic         cont;
        logic         rbtn;
        logic [W-1:0] sw;
        logic         e_run;
        logic         e_cont;
        logic         e_rst;
        logic [W-1:0] e_sw;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    slc3_input_conditioner_if #(.SW_WIDTH(W)) pins ();

    slc3_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SW_WIDTH       (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pins (pins)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic run, input logic cont,
                         input logic rb, input logic [W-1:0] sw);
        reset               = r;
        pins.run_btn_i      = run;
        pins.continue_btn_i = cont;
        pins.reset_btn_i    = rb;
        pins.sw_raw_i       = sw;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic run, input logic cont,
                                input logic rb, input logic [W-1:0] sw,
                                input logic er, input logic ec, input logic ers,
                                input logic [W-1:0] esw);
        vec_t v;
        v.rst_n = r;  v.run = run; v.cont = cont; v.rbtn = rb; v.sw = sw;
        v.e_run = er; v.e_cont = ec; v.e_rst = ers; v.e_sw = esw;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] sw_a;
        logic [W-1:0] sw_b;
        logic [W-1:0] sw_c;
        logic         bounce [8];
        sw_a = 16'hA5C3;
        sw_b = 16'h1234;
        sw_c = 16'h1235;
        bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held low three cycles: reset_o high, everything else idle.
        for (int k = 1; k <= 3; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
        // Stretched reset: reset_o high through edge 5, low from edge 6.
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, (k < 6), 16'h0000);
        // Clean run press held 20 cycles: one pulse at edge 6.
        for (int k = 1; k <= 20; k++) add(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, (k == 6), 1'b0, 1'b0, 16'h0000);
        // Release: no pulse.
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Simultaneous run + continue: both pulse at edge 6.
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, (k == 6), (k == 6), 1'b0, 16'h0000);
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Switch word appears atomically at edge 7.
        for (int k = 1; k <= 9; k++) add(1'b1, 1'b0, 1'b0, 1'b0, sw_a, 1'b0, 1'b0, 1'b0, (k >= 7) ? sw_a : 16'h0000);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].run, vecs[i].cont, vecs[i].rbtn, vecs[i].sw);
            cyc();
            chk($sformatf("vec%0d run_o", i),      {31'd0, pins.run_o},      {31'd0, vecs[i].e_run});
            chk($sformatf("vec%0d continue_o", i), {31'd0, pins.continue_o}, {31'd0, vecs[i].e_cont});
            chk($sformatf("vec%0d reset_o", i),    {31'd0, pins.reset_o},    {31'd0, vecs[i].e_rst});
            chk($sformatf("vec%0d sw_o", i),       {16'd0, pins.sw_o},       {16'd0, vecs[i].e_sw});
        end

        // Bounce: short 1/0 bursts never complete a count; the final
        // stable rise pulses once, on its 6th edge.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, bounce[k], 1'b0, 1'b0, sw_a);
            cyc();
            chk($sformatf("bounce%0d run_o", k), {31'd0, pins.run_o}, 32'd0);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, sw_a);
            cyc();
            chk($sformatf("stable%0d run_o", k), {31'd0, pins.run_o}, {31'd0, (k == 6)});
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, sw_a);
            cyc();
            chk($sformatf("release%0d run_o", k), {31'd0, pins.run_o}, 32'd0);
        end

        // Switch restart: one bit flips while the count is in progress, so
        // the intermediate word is never shown and the count starts over.
        for (int k = 1; k <= 14; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, (k <= 4) ? sw_b : sw_c);
            cyc();
            chk($sformatf("swrestart%0d sw_o", k), {16'd0, pins.sw_o},
                {16'd0, (k >= 11) ? sw_c : sw_a});
        end

        // Mid-count reset on a continue press.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, sw_c);
            cyc();
            chk($sformatf("midpre%0d continue_o", k), {31'd0, pins.continue_o}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, sw_c);
        #1;
        chk("midrst async reset_o", {31'd0, pins.reset_o}, 32'd1);
        chk("midrst async sw_o",    {16'd0, pins.sw_o},    32'd0);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            chk($sformatf("midrst%0d continue_o", k), {31'd0, pins.continue_o}, 32'd0);
            chk($sformatf("midrst%0d reset_o", k),    {31'd0, pins.reset_o},    32'd1);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, sw_c);
            cyc();
            chk($sformatf("midpost%0d continue_o", k), {31'd0, pins.continue_o}, {31'd0, (k == 6)});
            chk($sformatf("midpost%0d reset_o", k),    {31'd0, pins.reset_o},    {31'd0, (k < 6)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
